// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD card request arbiter.
// No logic; state encoding, op codes and address width only.
// Imported by the arbiter top and its round-robin picker.
package sd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    XFER,
    DONE
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int SECTOR_ADDR_W = 26;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the grant.
module rr_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W:0] w_pos;

  // Scan from the pointer, wrapping modulo NUM_REQ; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NUM_REQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (!o_any && i_req[w_pos[IDX_W-1:0]]) begin
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                     = w_pos[IDX_W-1:0];
        o_any                     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_request_arbiter.sv
// Shares one SD card controller between NUM_REQ sector requesters, round-robin.
// Latency: request seen in IDLE -> execute pulse 2 cycles later; done 2 cycles after sector edge.
// Backpressure: requests wait while the controller is busy; watchdog aborts stalled operations.
module sd_request_arbiter
  import sd_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_REQ-1:0]                i_req_valid,
  input  logic [NUM_REQ-1:0]                i_req_op,
  input  logic [NUM_REQ*SECTOR_ADDR_W-1:0]  i_req_sector,
  input  logic [NUM_REQ*8-1:0]              i_req_wdata,
  output logic [NUM_REQ-1:0]                o_req_grant,
  output logic [NUM_REQ-1:0]                o_req_byte_strobe,
  output logic [NUM_REQ-1:0]                o_req_done,
  output logic                              o_req_error,
  output logic [7:0]                        o_rsp_byte,
  output logic                              o_ctrl_op_code,
  output logic                              o_ctrl_execute,
  output logic [SECTOR_ADDR_W-1:0]          o_ctrl_sector_address,
  output logic [7:0]                        o_ctrl_outgoing_byte,
  input  logic [7:0]                        i_ctrl_incoming_byte,
  input  logic                              i_ctrl_finished_byte,
  input  logic                              i_ctrl_finished_sector,
  input  logic                              i_ctrl_busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(SECTOR_BYTES + 2);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t                r_state;
  logic [NUM_REQ-1:0]        r_grant;
  logic [IW-1:0]             r_idx;
  logic [IW-1:0]             r_rr_ptr;
  logic                      r_op;
  logic [SECTOR_ADDR_W-1:0]  r_sector;
  logic                      r_execute;
  logic [NUM_REQ-1:0]        r_strobe;
  logic [NUM_REQ-1:0]        r_done;
  logic                      r_error;
  logic [7:0]                r_rsp_byte;
  logic [CW-1:0]             r_byte_cnt;
  logic [WW-1:0]             r_wd_cnt;
  logic                      r_fb_d1, r_fb_d2, r_fs_d1, r_fs_d2;

  logic [NUM_REQ-1:0]        w_arb_grant;
  logic [IW-1:0]             w_arb_idx;
  logic                      w_arb_any;
  logic                      w_sel_op;
  logic [SECTOR_ADDR_W-1:0]  w_sel_sector;
  logic [7:0]                w_out_byte;
  logic                      w_fb_edge, w_fs_edge, w_wd_expired;
  logic [CW-1:0]             w_cnt_next, w_cnt_after;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IW)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  // Op and sector of the requester the picker would choose this cycle.
  always_comb begin
    w_sel_op     = 1'b0;
    w_sel_sector = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_idx == IW'(i)) begin
        w_sel_op     = i_req_op[i];
        w_sel_sector = i_req_sector[i*SECTOR_ADDR_W +: SECTOR_ADDR_W];
      end
    end
  end

  // Owner's write byte goes straight to the controller; idle bus reads as 0xFF.
  always_comb begin
    w_out_byte = 8'hFF;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_out_byte = i_req_wdata[i*8 +: 8];
      end
    end
  end

  assign w_fb_edge    = r_fb_d1 & ~r_fb_d2;
  assign w_fs_edge    = r_fs_d1 & ~r_fs_d2;
  assign w_wd_expired = (r_wd_cnt == WW'(TIMEOUT_CYCLES - 1));
  assign w_cnt_next   = (r_byte_cnt == CW'(SECTOR_BYTES + 1)) ? r_byte_cnt : r_byte_cnt + 1'b1;
  assign w_cnt_after  = w_fb_edge ? w_cnt_next : r_byte_cnt;

  // Register the controller's completion levels so edges can be detected in core_clk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fb_d1 <= 1'b0;
      r_fb_d2 <= 1'b0;
      r_fs_d1 <= 1'b0;
      r_fs_d2 <= 1'b0;
    end else begin
      r_fb_d1 <= i_ctrl_finished_byte;
      r_fb_d2 <= r_fb_d1;
      r_fs_d1 <= i_ctrl_finished_sector;
      r_fs_d2 <= r_fs_d1;
    end
  end

  // Operation sequencer: grant, execute pulse, byte transfer, completion with error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_op       <= OP_READ;
      r_sector   <= '0;
      r_execute  <= 1'b0;
      r_strobe   <= '0;
      r_done     <= '0;
      r_error    <= 1'b0;
      r_rsp_byte <= '0;
      r_byte_cnt <= '0;
      r_wd_cnt   <= '0;
    end else begin
      r_execute <= 1'b0;
      r_strobe  <= '0;
      r_done    <= '0;
      r_error   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!i_ctrl_busy && w_arb_any) begin
            r_grant  <= w_arb_grant;
            r_idx    <= w_arb_idx;
            r_op     <= w_sel_op ? OP_WRITE : OP_READ;
            r_sector <= w_sel_sector;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          r_execute  <= 1'b1;
          r_byte_cnt <= '0;
          r_wd_cnt   <= '0;
          r_state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (w_wd_expired) begin
            r_done  <= r_grant;
            r_error <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
            if (i_ctrl_busy) begin
              r_state <= XFER;
            end
          end
        end
        XFER: begin
          if (w_fb_edge) begin
            if (r_op == OP_READ) begin
              r_rsp_byte <= i_ctrl_incoming_byte;
            end
            r_strobe   <= r_grant;
            r_byte_cnt <= w_cnt_next;
          end
          if (w_fs_edge) begin
            r_done  <= r_grant;
            r_error <= (w_cnt_after != CW'(SECTOR_BYTES));
            r_state <= DONE;
          end else if (w_wd_expired) begin
            r_done  <= r_grant;
            r_error <= 1'b1;
            r_state <= DONE;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
        end
        DONE: begin
          r_grant  <= '0;
          r_rr_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_grant           = r_grant;
  assign o_req_byte_strobe     = r_strobe;
  assign o_req_done            = r_done;
  assign o_req_error           = r_error;
  assign o_rsp_byte            = r_rsp_byte;
  assign o_ctrl_op_code        = r_op;
  assign o_ctrl_execute        = r_execute;
  assign o_ctrl_sector_address = r_sector;
  assign o_ctrl_outgoing_byte  = w_out_byte;

endmodule

// File: tb/tb_sd_request_arbiter.sv
`timescale 1ns/1ps
module tb_sd_request_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_op;
  logic [51:0] req_sector;
  logic [7:0]  wd0, wd1_base;
  logic [15:0] req_wdata;
  logic [7:0]  inc_byte;
  logic        fb, fs, busy;
  int          s1cnt = 0;
  int          stb_cnt = 0;

  logic [1:0]  o_grant, o_strobe, o_done;
  logic        o_err, o_op, o_exec;
  logic [7:0]  o_rsp, o_outb;
  logic [25:0] o_addr;

  // Second instance with a short watchdog; controller inputs tied idle.
  logic [1:0]  to_valid;
  logic [1:0]  to_grant, to_strobe, to_done;
  logic        to_err, to_op, to_exec;
  logic [7:0]  to_rsp, to_outb;
  logic [25:0] to_addr;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [1:0]  exp_oh   = 2'b00;
  bit          exp_read = 1'b0;
  logic [7:0]  q_rd[$];

  // Requester 1 presents the next write byte after every strobe it receives.
  assign req_wdata = {wd1_base + s1cnt[7:0], wd0};

  sd_request_arbiter #(.NUM_REQ(2), .SECTOR_BYTES(512), .TIMEOUT_CYCLES(1_000_000)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .i_req_op(req_op), .i_req_sector(req_sector), .i_req_wdata(req_wdata),
    .o_req_grant(o_grant), .o_req_byte_strobe(o_strobe), .o_req_done(o_done), .o_req_error(o_err),
    .o_rsp_byte(o_rsp), .o_ctrl_op_code(o_op), .o_ctrl_execute(o_exec),
    .o_ctrl_sector_address(o_addr), .o_ctrl_outgoing_byte(o_outb),
    .i_ctrl_incoming_byte(inc_byte), .i_ctrl_finished_byte(fb),
    .i_ctrl_finished_sector(fs), .i_ctrl_busy(busy)
  );

  sd_request_arbiter #(.NUM_REQ(2), .SECTOR_BYTES(512), .TIMEOUT_CYCLES(1000)) u_to (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(to_valid), .i_req_op(2'b00), .i_req_sector(req_sector), .i_req_wdata(req_wdata),
    .o_req_grant(to_grant), .o_req_byte_strobe(to_strobe), .o_req_done(to_done), .o_req_error(to_err),
    .o_rsp_byte(to_rsp), .o_ctrl_op_code(to_op), .o_ctrl_execute(to_exec),
    .o_ctrl_sector_address(to_addr), .o_ctrl_outgoing_byte(to_outb),
    .i_ctrl_incoming_byte(8'h00), .i_ctrl_finished_byte(1'b0),
    .i_ctrl_finished_sector(1'b0), .i_ctrl_busy(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every strobe goes to the expected owner; read bytes pop in order.
  always @(negedge clk) begin
    if (!rst && (o_strobe != 2'b00)) begin
      stb_cnt++;
      if (o_strobe[1]) s1cnt++;
      chk("strobe_owner", 32'(o_strobe), 32'(exp_oh));
      if (exp_read) begin
        if (q_rd.size() != 0) chk("rsp_byte", 32'(o_rsp), 32'(q_rd.pop_front()));
        else chk("rsp_unexpected_strobe", 32'(q_rd.size()), 32'd1);
      end
    end
  end

  // Waits for the execute pulse; lat>0 also demands exactly that many cycles.
  task automatic wait_exec(input logic [1:0] oh, input logic op, input logic [25:0] addr, input int lat);
    int n;
    n = 0;
    while (!o_exec && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("exec_seen", 32'(o_exec), 32'd1);
    if (lat > 0) chk("exec_latency", 32'(n), 32'(lat));
    chk("exec_grant", 32'(o_grant), 32'(oh));
    chk("exec_op", 32'(o_op), 32'(op));
    chk("exec_addr", 32'(o_addr), 32'(addr));
    exp_oh = oh;
    @(negedge clk);
    chk("exec_one_cycle", 32'(o_exec), 32'd0);
  endtask

  // Controller model: busy, nbytes byte handshakes, then optionally finished_sector.
  task automatic serve(input int nbytes, input bit rd, input logic [7:0] seed, input bit fin);
    logic [7:0] v;
    exp_read = rd;
    busy = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      v = seed + 8'(k);
      if (rd) begin
        inc_byte = v;
        q_rd.push_back(v);
      end else begin
        chk("wr_byte", 32'(o_outb), 32'(v));
      end
      fb = 1'b1;
      repeat (3) @(negedge clk);
      fb = 1'b0;
      @(negedge clk);
    end
    if (fin) fs = 1'b1;
  endtask

  task automatic wait_done(input logic [1:0] oh, input logic err);
    int n;
    n = 0;
    while (o_done == 2'b00 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("done_owner", 32'(o_done), 32'(oh));
    chk("done_err", 32'(o_err), 32'(err));
    chk("rd_queue_drained", 32'(q_rd.size()), 32'd0);
    req_valid = req_valid & ~oh;
    fs   = 1'b0;
    busy = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", 32'(o_done), 32'd0);
    chk("err_one_cycle", 32'(o_err), 32'd0);
    chk("grant_released", 32'(o_grant), 32'd0);
    chk("outb_idle_ff", 32'(o_outb), 32'hFF);
  endtask

  initial begin
    #300_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s0, n;
    rst = 1'b1;
    req_valid = 2'b00; req_op = 2'b00; req_sector = '0;
    wd0 = 8'hA5; wd1_base = 8'h10;
    inc_byte = 8'h00; fb = 1'b0; fs = 1'b0; busy = 1'b0;
    to_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_strobe", 32'(o_strobe), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_rsp", 32'(o_rsp), 32'd0);
    chk("rst_exec", 32'(o_exec), 32'd0);
    chk("rst_op", 32'(o_op), 32'd0);
    chk("rst_addr", 32'(o_addr), 32'd0);
    chk("rst_outb", 32'(o_outb), 32'hFF);
    chk("rst_to_outs", 32'({to_grant, to_strobe, to_done, to_err, to_exec, to_op}), 32'd0);
    chk("rst_to_data", 32'({to_rsp, to_addr}), 32'd0);
    chk("rst_to_outb", 32'(to_outb), 32'hFF);
    rst = 1'b0;
    @(negedge clk);

    // 1: single full-sector read by requester 0.
    req_sector[25:0] = 26'h12; req_op = 2'b00; req_valid = 2'b01;
    wait_exec(2'b01, 1'b0, 26'h12, 2);
    s0 = stb_cnt;
    serve(512, 1'b1, 8'h00, 1'b1);
    wait_done(2'b01, 1'b0);
    chk("rd_strobe_count", 32'(stb_cnt - s0), 32'd512);

    // 3: full-sector write by requester 1; controller sees only its bytes.
    req_sector[51:26] = 26'h3000001; req_op = 2'b10; req_valid = 2'b10;
    wait_exec(2'b10, 1'b1, 26'h3000001, 2);
    s0 = stb_cnt;
    serve(512, 1'b0, req_wdata[15:8], 1'b1);
    wait_done(2'b10, 1'b0);
    chk("wr_strobe_count", 32'(stb_cnt - s0), 32'd512);

    // 2: contention with pointer at 0; requester 0 re-requests after its turn.
    req_op = 2'b00; req_sector[25:0] = 26'h100; req_sector[51:26] = 26'h200;
    req_valid = 2'b11;
    wait_exec(2'b01, 1'b0, 26'h100, 2);
    serve(8, 1'b1, 8'h80, 1'b1);
    wait_done(2'b01, 1'b1);
    req_valid[0] = 1'b1;
    wait_exec(2'b10, 1'b0, 26'h200, 0);
    serve(8, 1'b1, 8'hC0, 1'b1);
    wait_done(2'b10, 1'b1);
    wait_exec(2'b01, 1'b0, 26'h100, 0);
    serve(8, 1'b1, 8'hE0, 1'b1);
    wait_done(2'b01, 1'b1);

    // 4: short sector of 100 bytes flags an error and returns to idle.
    req_sector[25:0] = 26'h55; req_valid = 2'b01;
    wait_exec(2'b01, 1'b0, 26'h55, 2);
    s0 = stb_cnt;
    serve(100, 1'b1, 8'h20, 1'b1);
    wait_done(2'b01, 1'b1);
    chk("short_strobe_count", 32'(stb_cnt - s0), 32'd100);
    repeat (3) @(negedge clk);
    chk("short_stays_idle", 32'({o_exec, o_grant}), 32'd0);

    // 5: controller never goes busy; watchdog ends the op 1000 cycles after execute.
    to_valid = 2'b01;
    n = 0;
    while (!to_exec && n < 20) begin @(negedge clk); n++; end
    chk("to_exec_latency", 32'(n), 32'd2);
    n = 0;
    while (to_done == 2'b00 && n < 1100) begin @(negedge clk); n++; end
    chk("to_done_cycles", 32'(n), 32'd1000);
    chk("to_done_owner", 32'(to_done), 32'd1);
    chk("to_error", 32'(to_err), 32'd1);
    to_valid = 2'b00;

    // 6: asynchronous reset in the middle of a read.
    req_sector[25:0] = 26'h2ABCDE; req_valid = 2'b01;
    wait_exec(2'b01, 1'b0, 26'h2ABCDE, 2);
    serve(10, 1'b1, 8'h40, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(o_grant), 32'd0);
    chk("arst_strobe_done_err", 32'({o_strobe, o_done, o_err}), 32'd0);
    chk("arst_rsp", 32'(o_rsp), 32'd0);
    chk("arst_exec_op", 32'({o_exec, o_op}), 32'd0);
    chk("arst_addr", 32'(o_addr), 32'd0);
    busy = 1'b0;
    q_rd.delete();
    @(negedge clk);
    rst = 1'b0;
    wait_exec(2'b01, 1'b0, 26'h2ABCDE, 2);
    serve(3, 1'b1, 8'h60, 1'b1);
    wait_done(2'b01, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
